// File: rtl/t1b_color_uart_tx.sv
// Sends "<colour letter>\r\n" over UART 8N1 for every colour decision of the TCS3200 detector.
// One message may wait in a pending slot while another is on the line; the newest pending letter wins.
module t1b_color_uart_tx #(
  parameter int CLKS_PER_BIT = 9
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic [1:0] filter,
  input  logic [1:0] color,
  output logic       tx,
  output logic       busy,
  output logic [7:0] msg_count,
  output logic       overrun
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [1:0]       byte_idx_q;
  logic [7:0]       letter_q;
  logic             pend_valid_q;
  logic [7:0]       pend_letter_q;
  logic [1:0]       filter_q;
  logic             arm_q;
  logic             arm_d;
  logic             tx_q;
  logic [7:0]       msg_count_q;
  logic             overrun_q;

  logic       cap_valid;
  logic [7:0] cap_letter;
  logic [7:0] cur_byte;
  logic       bit_done;
  logic       msg_done;

  // Arm on the edge filter enters "clear"; capture one edge later so colour has settled.
  always_comb begin
    arm_d = arm_q;
    if (filter == 2'd2 && filter_q != 2'd2) begin
      arm_d = 1'b1;
    end else if (arm_q) begin
      arm_d = 1'b0;
    end
  end

  always_comb begin
    cap_valid  = arm_q && (color != 2'd0);
    cap_letter = 8'h52;
    case (color)
      2'd2:    cap_letter = 8'h47;
      2'd3:    cap_letter = 8'h42;
      default: cap_letter = 8'h52;
    endcase
  end

  always_comb begin
    case (byte_idx_q)
      2'd0:    cur_byte = letter_q;
      2'd1:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  assign bit_done = (cnt_q == CNT_MAX);
  assign msg_done = (state_q == STOP) && bit_done && (byte_idx_q == 2'd2);

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      byte_idx_q    <= '0;
      letter_q      <= '0;
      pend_valid_q  <= 1'b0;
      pend_letter_q <= '0;
      filter_q      <= '0;
      arm_q         <= 1'b0;
      tx_q          <= 1'b1;
      msg_count_q   <= '0;
      overrun_q     <= 1'b0;
    end else begin
      filter_q  <= filter;
      arm_q     <= arm_d;
      overrun_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cap_valid && !pend_valid_q) begin
            letter_q   <= cap_letter;
            byte_idx_q <= 2'd0;
            cnt_q      <= '0;
            tx_q       <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (bit_done) begin
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            tx_q      <= cur_byte[0];
            state_q   <= DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= cur_byte[bit_idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt_q <= '0;
            tx_q  <= 1'b0;
            if (byte_idx_q != 2'd2) begin
              byte_idx_q <= byte_idx_q + 2'd1;
              state_q    <= START;
            end else begin
              // Message complete: chain straight into the pending letter, or a same-edge capture.
              msg_count_q <= msg_count_q + 8'd1;
              byte_idx_q  <= 2'd0;
              if (pend_valid_q) begin
                letter_q <= pend_letter_q;
                state_q  <= START;
              end else if (cap_valid) begin
                letter_q <= cap_letter;
                state_q  <= START;
              end else begin
                tx_q    <= 1'b1;
                state_q <= IDLE;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase

      // Pending slot: the pending letter is consumed before a same-edge capture refills it.
      if (msg_done && pend_valid_q) begin
        pend_valid_q <= cap_valid;
        if (cap_valid) begin
          pend_letter_q <= cap_letter;
        end
      end else if (cap_valid && !msg_done && (state_q != IDLE || pend_valid_q)) begin
        pend_letter_q <= cap_letter;
        pend_valid_q  <= 1'b1;
        overrun_q     <= pend_valid_q;
      end
    end
  end

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) | pend_valid_q;
  assign msg_count = msg_count_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_t1b_color_uart_tx.sv
// Directed bench for t1b_color_uart_tx: decision timing, frame bits, pending/overrun and reset behaviour.
`timescale 1ns/1ps
module tb_t1b_color_uart_tx;

  logic       clk_1MHz = 1'b0;
  logic       rst_n    = 1'b0;
  logic [1:0] filter   = 2'd0;
  logic [1:0] color    = 2'd0;
  logic       tx;
  logic       busy;
  logic [7:0] msg_count;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  always #500 clk_1MHz = ~clk_1MHz;

  t1b_color_uart_tx #(.CLKS_PER_BIT(9)) dut (
    .clk_1MHz (clk_1MHz),
    .rst_n    (rst_n),
    .filter   (filter),
    .color    (color),
    .tx       (tx),
    .busy     (busy),
    .msg_count(msg_count),
    .overrun  (overrun)
  );

  task automatic step();
    @(negedge clk_1MHz);
  endtask

  // Expected line level for bit k (0..29) of the message "<letter>\r\n".
  function automatic logic frame_bit(input logic [7:0] letter, input int k);
    logic [7:0] b;
    int pos;
    case (k / 10)
      0:       b = letter;
      1:       b = 8'h0D;
      default: b = 8'h0A;
    endcase
    pos = k % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  // Observes 270 cycles from the first start-bit cycle; counts bad cycles and overrun pulses.
  task automatic watch_msg(input logic [7:0] letter, output int bad, output int ovr);
    bad = 0;
    ovr = 0;
    for (int c = 0; c < 270; c++) begin
      if (tx !== frame_bit(letter, c / 9) || busy !== 1'b1) bad++;
      if (overrun === 1'b1) ovr++;
      step();
    end
    $display("[TB] message 0x%02h observed, %0d bad cycles, %0d overrun cycles", letter, bad, ovr);
  endtask

  task automatic watch_idle(input int n, output int bad);
    bad = 0;
    for (int c = 0; c < n; c++) begin
      if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) bad++;
      step();
    end
    $display("[TB] idle window of %0d cycles observed, %0d bad cycles", n, bad);
  endtask

  task automatic test_reset();
    int bad_tx, bad_busy, bad_cnt, bad_ovr;
    bad_tx = 0; bad_busy = 0; bad_cnt = 0; bad_ovr = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      filter = 2'(i % 4);
      color  = 2'((i + 1) % 4);
      step();
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (msg_count !== 8'd0) bad_cnt++;
      if (overrun !== 1'b0) bad_ovr++;
    end
    tests++; if (bad_tx != 0)   begin fails++; $display("FAIL reset_tx: %0d cycles with tx!=1, required 0", bad_tx); end
    tests++; if (bad_busy != 0) begin fails++; $display("FAIL reset_busy: %0d cycles with busy!=0, required 0", bad_busy); end
    tests++; if (bad_cnt != 0)  begin fails++; $display("FAIL reset_count: %0d cycles with msg_count!=0, required 0", bad_cnt); end
    tests++; if (bad_ovr != 0)  begin fails++; $display("FAIL reset_overrun: %0d cycles with overrun!=0, required 0", bad_ovr); end
    filter = 2'd0;
    color  = 2'd0;
    rst_n  = 1'b1;
    step();
    $display("[TB] reset test done");
  endtask

  task automatic test_single_red();
    int bad, ovr;
    filter = 2'd3; step();
    filter = 2'd0; step();
    filter = 2'd1; step();
    filter = 2'd2; color = 2'd1;
    step();
    tests++; if (tx !== 1'b1)   begin fails++; $display("FAIL red_arm_tx: tx=%b required 1", tx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL red_arm_busy: busy=%b required 0", busy); end
    step();
    watch_msg(8'h52, bad, ovr);
    tests++; if (bad != 0) begin fails++; $display("FAIL red_frame: %0d bad cycles, required 0", bad); end
    tests++; if (ovr != 0) begin fails++; $display("FAIL red_overrun: %0d pulses, required 0", ovr); end
    tests++; if (msg_count !== 8'd1) begin fails++; $display("FAIL red_count: msg_count=%0d required 1", msg_count); end
    tests++; if (busy !== 1'b0 || tx !== 1'b1) begin fails++; $display("FAIL red_end: busy=%b tx=%b required busy=0 tx=1", busy, tx); end
    filter = 2'd0;
    step();
  endtask

  task automatic test_no_color();
    int bad;
    filter = 2'd0; color = 2'd0; step();
    filter = 2'd2;
    watch_idle(40, bad);
    tests++; if (bad != 0) begin fails++; $display("FAIL nocolor_idle: %0d bad cycles, required 0", bad); end
    tests++; if (msg_count !== 8'd1) begin fails++; $display("FAIL nocolor_count: msg_count=%0d required 1", msg_count); end
    filter = 2'd0;
    step();
  endtask

  task automatic test_pending_overrun();
    int bad_r, ovr_r, bad_b, ovr_b;
    rst_n = 1'b0; filter = 2'd0; color = 2'd0;
    step(); step();
    rst_n = 1'b1;
    step();
    filter = 2'd2; color = 2'd1;
    step(); step();
    fork
      begin
        repeat (5)  step(); filter = 2'd0;
        repeat (5)  step(); filter = 2'd2; color = 2'd2;
        repeat (3)  step(); filter = 2'd0;
        repeat (37) step(); filter = 2'd2; color = 2'd3;
        repeat (3)  step(); filter = 2'd0;
      end
      begin
        watch_msg(8'h52, bad_r, ovr_r);
      end
    join
    tests++; if (bad_r != 0) begin fails++; $display("FAIL pend_red_frame: %0d bad cycles, required 0", bad_r); end
    tests++; if (msg_count !== 8'd1) begin fails++; $display("FAIL pend_mid_count: msg_count=%0d required 1", msg_count); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL pend_mid_busy: busy=%b required 1", busy); end
    watch_msg(8'h42, bad_b, ovr_b);
    tests++; if (bad_b != 0) begin fails++; $display("FAIL pend_blue_frame: %0d bad cycles, required 0", bad_b); end
    tests++; if (ovr_r + ovr_b != 1) begin fails++; $display("FAIL pend_overrun: %0d pulses, required 1", ovr_r + ovr_b); end
    tests++; if (msg_count !== 8'd2) begin fails++; $display("FAIL pend_count: msg_count=%0d required 2", msg_count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL pend_end_busy: busy=%b required 0", busy); end
  endtask

  task automatic test_held_filter();
    int bad, ovr, bad_idle;
    filter = 2'd0; color = 2'd3;
    step(); step();
    filter = 2'd2;
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL held_arm_busy: busy=%b required 0", busy); end
    step();
    watch_msg(8'h42, bad, ovr);
    tests++; if (bad != 0) begin fails++; $display("FAIL held_frame: %0d bad cycles, required 0", bad); end
    watch_idle(1728, bad_idle);
    tests++; if (bad_idle != 0) begin fails++; $display("FAIL held_single: %0d bad idle cycles, required 0", bad_idle); end
    tests++; if (msg_count !== 8'd3) begin fails++; $display("FAIL held_count: msg_count=%0d required 3", msg_count); end
    filter = 2'd0;
    step();
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    filter = 2'd2; color = 2'd1;
    step(); step();
    repeat (44) step();
    tests++; if (tx !== 1'b0) begin fails++; $display("FAIL mid_bit3: tx=%b required 0", tx); end
    step();
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_bit4: tx=%b required 1", tx); end
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_reset_tx: tx=%b required 1", tx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy: busy=%b required 0", busy); end
    tests++; if (msg_count !== 8'd0) begin fails++; $display("FAIL mid_reset_count: msg_count=%0d required 0", msg_count); end
    filter = 2'd0;
    step(); step();
    rst_n = 1'b1;
    watch_idle(300, bad);
    tests++; if (bad != 0) begin fails++; $display("FAIL mid_after_release: %0d bad cycles, required 0", bad); end
    tests++; if (msg_count !== 8'd0) begin fails++; $display("FAIL mid_final_count: msg_count=%0d required 0", msg_count); end
  endtask

  initial begin
    test_reset();
    test_single_red();
    test_no_color();
    test_pending_overrun();
    test_held_filter();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
